// File: rtl/fanin_merge_pkg.sv
// Shared types, defaults and helpers for the round-robin fan-in merger.
package fanin_merge_pkg;

    localparam int DEFAULT_NUM_LANES = 16;
    localparam int DEFAULT_DATA_W    = 8;
    localparam int LANE_IDX_W        = $clog2(DEFAULT_NUM_LANES);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Modulo-n increment of a lane index; n need not be a power of two.
    function automatic int next_lane(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fanin_merge_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or above ptr,
// wrapping modulo NUM_LANES. Purely combinational.
module rr_arbiter
    import fanin_merge_pkg::*;
#(
    parameter  int NUM_LANES = DEFAULT_NUM_LANES,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    ptr,
    input  logic                 en,
    output logic [NUM_LANES-1:0] grant,
    output logic [LANE_W-1:0]    grant_idx,
    output logic                 any_grant
);

    // Walk lanes upward from ptr; the first requester found wins.
    always_comb begin
        int          idx;
        logic [LANE_W-1:0] idx_l;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_l     = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            idx_l = LANE_W'(idx);
            if (en && !any_grant && req[idx_l]) begin
                any_grant    = 1'b1;
                grant[idx_l] = 1'b1;
                grant_idx    = idx_l;
            end
        end
    end

endmodule

// File: rtl/fanin_merge.sv
// Fan-in merger: many valid/ready lanes funnel into one registered output,
// chosen round-robin so every lane gets a fair share of the sink.
module fanin_merge
    import fanin_merge_pkg::*;
#(
    parameter  int NUM_LANES = DEFAULT_NUM_LANES,
    parameter  int DATA_W    = DEFAULT_DATA_W,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANES-1:0]        in_valid,
    output logic [NUM_LANES-1:0]        in_ready,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [LANE_W-1:0]           out_lane
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [LANE_W-1:0] out_lane_q,  out_lane_d;
    logic [LANE_W-1:0] ptr_q,       ptr_d;

    logic              load;
    logic              arb_en;
    logic [NUM_LANES-1:0] grant;
    logic [LANE_W-1:0] grant_idx;
    logic              any_grant;
    logic [DATA_W-1:0] sel_data;

    // The holding register can take a new word when empty or being drained;
    // reset also blocks grants so no lane sees ready while rst is high.
    assign load   = !out_valid_q || out_ready;
    assign arb_en = load && !rst;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // One-hot AND-OR data mux driven by the arbiter grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for the holding register and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (any_grant) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_lane_d  = grant_idx;
                ptr_d       = LANE_W'(next_lane(int'(grant_idx), NUM_LANES));
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset that discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            ptr_q       <= ptr_d;
        end
    end

    assign in_ready  = grant;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;

endmodule

// File: tb/tb_fanin_merge.sv
// Self-checking bench for fanin_merge: a behavioural model checked every
// cycle for the 16-lane instance, plus directed literal expectations and a
// 5-lane instance for the non-power-of-two case.
module tb_fanin_merge;

    logic         clk;
    logic         rst;
    logic [15:0]  in_valid;
    logic [15:0]  in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_lane;

    logic [4:0]   in_valid5;
    logic [4:0]   in_ready5;
    logic [39:0]  in_data5;
    logic         out_valid5;
    logic         out_ready5;
    logic [7:0]   out_data5;
    logic [2:0]   out_lane5;

    int checks = 0;
    int errors = 0;

    // Model state for the 16-lane instance
    int         m_ptr;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_lane;

    fanin_merge #(.NUM_LANES(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane)
    );

    fanin_merge #(.NUM_LANES(5), .DATA_W(8)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_data   (in_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_data  (out_data5),
        .out_lane  (out_lane5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which lane the rules say is granted this cycle, or -1 for none.
    function automatic int modelPick();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < 16; k++) begin
            if (in_valid[(m_ptr + k) % 16]) return (m_ptr + k) % 16;
        end
        return -1;
    endfunction

    // Reference model update on each clock edge / reset.
    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_lane  = 0;
        end else begin
            g = modelPick();
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*8 +: 8];
                m_lane  = g;
                m_ptr   = (g + 1) % 16;
            end else if (!m_valid || out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare the 16-lane DUT against the model every cycle.
    always @(negedge clk) begin
        int g;
        logic [15:0] exp_ready;
        g = modelPick();
        exp_ready = (g >= 0) ? (16'h0001 << g) : 16'h0000;
        checkOutput("model_out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("model_out_data",  64'(out_data),  64'(m_data));
        checkOutput("model_out_lane",  64'(out_lane),  64'(m_lane));
        checkOutput("model_in_ready",  64'(in_ready),  64'(exp_ready));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [15:0] valid, input logic ready);
        in_valid  = valid;
        out_ready = ready;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = '0;
        out_ready  = 1'b0;
        in_valid5  = '0;
        out_ready5 = 1'b0;
        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
        for (int i = 0; i < 5; i++)  in_data5[i*8 +: 8] = 8'(8'h50 + i);

        repeat (2) tick();
        rst = 1'b0;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_lane",  64'(out_lane),  64'd0);
        checkOutput("reset_data",  64'(out_data),  64'd0);

        // Load a word, then assert reset mid-cycle while it is held
        applyStimulus(16'h0010, 1'b0);
        tick();
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        checkOutput("pre_reset_lane",  64'(out_lane),  64'd4);
        applyStimulus(16'h0208, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("async_reset_data",  64'(out_data),  64'd0);
        checkOutput("async_reset_lane",  64'(out_lane),  64'd0);
        checkOutput("async_reset_ready", 64'(in_ready),  64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(16'h0208, 1'b1);
        #1;
        checkOutput("post_reset_ready", 64'(in_ready), 64'h0008);
        tick();
        checkOutput("post_reset_lane", 64'(out_lane), 64'd3);
        checkOutput("post_reset_data", 64'(out_data), 64'h13);

        // Full contention from a fresh pointer
        applyStimulus(16'h0000, 1'b1);
        pulseReset();
        applyStimulus(16'hFFFF, 1'b1);
        for (int k = 0; k < 17; k++) begin
            tick();
            checkOutput("full_valid", 64'(out_valid), 64'd1);
            checkOutput("full_lane",  64'(out_lane),  64'(k % 16));
            checkOutput("full_data",  64'(out_data),  64'(8'h10 + (k % 16)));
        end

        // Backpressure: lanes 2 and 7, sink stalled for five cycles
        applyStimulus(16'h0000, 1'b1);
        tick();
        checkOutput("drain_valid", 64'(out_valid), 64'd0);
        applyStimulus(16'h0084, 1'b0);
        tick();
        checkOutput("bp_first_lane", 64'(out_lane), 64'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_lane",  64'(out_lane),  64'd2);
            checkOutput("bp_hold_data",  64'(out_data),  64'h12);
            checkOutput("bp_hold_ready", 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(in_ready), 64'h0080);
        tick();
        checkOutput("bp_next_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_next_lane",  64'(out_lane),  64'd7);
        checkOutput("bp_next_data",  64'(out_data),  64'h17);

        // Wrap: bring ptr to 14 via lane 13, then lanes 1 and 15
        applyStimulus(16'h2000, 1'b1);
        tick();
        checkOutput("wrap_setup_lane", 64'(out_lane), 64'd13);
        applyStimulus(16'h8002, 1'b1);
        tick();
        checkOutput("wrap_first_lane", 64'(out_lane), 64'd15);
        tick();
        checkOutput("wrap_second_lane", 64'(out_lane), 64'd1);
        applyStimulus(16'h0006, 1'b1);
        tick();
        checkOutput("wrap_ptr_is_2", 64'(out_lane), 64'd2);
        applyStimulus(16'h0000, 1'b1);
        tick();
        checkOutput("wrap_idle_valid", 64'(out_valid), 64'd0);

        // Sparse single pulse on lane 5
        in_data[5*8 +: 8] = 8'hA5;
        applyStimulus(16'h0020, 1'b1);
        tick();
        checkOutput("sparse_valid", 64'(out_valid), 64'd1);
        checkOutput("sparse_lane",  64'(out_lane),  64'd5);
        checkOutput("sparse_data",  64'(out_data),  64'hA5);
        applyStimulus(16'h0000, 1'b1);
        tick();
        checkOutput("sparse_drop_valid", 64'(out_valid), 64'd0);
        tick();
        checkOutput("sparse_idle_valid", 64'(out_valid), 64'd0);

        // Five-lane instance: order 0..4,0
        pulseReset();
        in_valid5  = 5'b11111;
        out_ready5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("n5_valid", 64'(out_valid5), 64'd1);
            checkOutput("n5_lane",  64'(out_lane5),  64'(k % 5));
            checkOutput("n5_data",  64'(out_data5),  64'(8'h50 + (k % 5)));
        end
        in_valid5 = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
